// File: rtl/exec_alu_mc_if.sv
// Handshake and operand bus for the multi-cycle execute-stage ALU.
// The master drives the op request, and the slave (the ALU) returns the registered result and flags.
interface exec_alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] dst;
  logic [WIDTH-1:0] in_port;
  logic             flush;
  logic             ccr_load;
  logic [2:0]       ccr_in;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [2:0]       ccr;
  logic             busy;

  modport master (
    output in_valid, op, src, dst, in_port, flush, ccr_load, ccr_in,
    input  in_ready, out_valid, result, ccr, busy
  );

  modport slave (
    input  in_valid, op, src, dst, in_port, flush, ccr_load, ccr_in,
    output in_ready, out_valid, result, ccr, busy
  );
endinterface

// File: rtl/exec_alu_mc.sv
// Execute-stage ALU with a registered result and {C,N,Z} condition codes.
// Most ops complete in one cycle. SHL/SHR shift one bit per cycle, and MUL runs a
// WIDTH-step shift-add. The block drops in_ready while a multi-cycle op is running,
// which lets the pipeline stall.
module exec_alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic          clk,
  input logic          rst,
  exec_alu_mc_if.slave bus
);
  localparam int CW = SHW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_INC  = 4'd5;
  localparam logic [3:0] OP_DEC  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;
  localparam logic [3:0] OP_IN   = 4'd11;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;     // value being shifted
  logic             shl_q, shl_d;       // shift direction: 1 = left
  logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d; // upper half of the 2*WIDTH product
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d; // multiplier, replaced by the product's low half
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       ccr_q, ccr_d;       // {C,N,Z}
  logic             out_valid_q, out_valid_d;

  logic [SHW-1:0]   n_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   psum_s;
  logic [WIDTH-1:0] fin_res_s;
  logic             fin_c_s;
  logic             fin_zn_s;
  logic             fin_cu_s;
  logic             fin_done_s;

  assign n_s           = bus.src[SHW-1:0];
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ccr       = ccr_q;

  // Next-state, datapath step and flag update for the accept and iterate phases.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    shl_d       = shl_q;
    mcand_d     = mcand_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    result_d    = result_q;
    ccr_d       = ccr_q;
    out_valid_d = 1'b0;
    sum_s       = {(WIDTH+1){1'b0}};
    psum_s      = {(WIDTH+1){1'b0}};
    fin_res_s   = {WIDTH{1'b0}};
    fin_c_s     = 1'b0;
    fin_zn_s    = 1'b0;
    fin_cu_s    = 1'b0;
    fin_done_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          case (bus.op)
            OP_ADD: begin
              sum_s      = {1'b0, bus.src} + {1'b0, bus.dst};
              fin_res_s  = sum_s[WIDTH-1:0];
              fin_c_s    = sum_s[WIDTH];
              fin_zn_s   = 1'b1;
              fin_cu_s   = 1'b1;
              fin_done_s = 1'b1;
            end
            OP_SUB: begin
              // The extra top bit of the widened difference is the borrow (dst < src).
              sum_s      = {1'b0, bus.dst} - {1'b0, bus.src};
              fin_res_s  = sum_s[WIDTH-1:0];
              fin_c_s    = sum_s[WIDTH];
              fin_zn_s   = 1'b1;
              fin_cu_s   = 1'b1;
              fin_done_s = 1'b1;
            end
            OP_AND: begin
              fin_res_s  = bus.src & bus.dst;
              fin_zn_s   = 1'b1;
              fin_done_s = 1'b1;
            end
            OP_OR: begin
              fin_res_s  = bus.src | bus.dst;
              fin_zn_s   = 1'b1;
              fin_done_s = 1'b1;
            end
            OP_NOT: begin
              fin_res_s  = ~bus.dst;
              fin_zn_s   = 1'b1;
              fin_done_s = 1'b1;
            end
            OP_INC: begin
              fin_res_s  = bus.dst + ONE;
              fin_c_s    = &bus.dst;
              fin_zn_s   = 1'b1;
              fin_cu_s   = 1'b1;
              fin_done_s = 1'b1;
            end
            OP_DEC: begin
              fin_res_s  = bus.dst - ONE;
              fin_c_s    = ~|bus.dst;
              fin_zn_s   = 1'b1;
              fin_cu_s   = 1'b1;
              fin_done_s = 1'b1;
            end
            OP_SHL, OP_SHR: begin
              if (n_s == {SHW{1'b0}}) begin
                // A zero shift leaves the value unchanged. It finishes at once and keeps C.
                fin_res_s  = bus.dst;
                fin_zn_s   = 1'b1;
                fin_done_s = 1'b1;
              end else begin
                state_d = S_SHIFT;
                cnt_d   = {1'b0, n_s};
                work_d  = bus.dst;
                shl_d   = (bus.op == OP_SHL);
              end
            end
            OP_MUL: begin
              state_d  = S_MUL;
              cnt_d    = CW'(WIDTH);
              mcand_d  = bus.src;
              acc_hi_d = {WIDTH{1'b0}};
              acc_lo_d = bus.dst;
            end
            OP_PASS: begin
              fin_res_s  = bus.src;
              fin_done_s = 1'b1;
            end
            OP_IN: begin
              fin_res_s  = bus.in_port;
              fin_done_s = 1'b1;
            end
            default: begin
              fin_res_s  = {WIDTH{1'b0}};
              fin_done_s = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          if (shl_q) begin
            work_d  = {work_q[WIDTH-2:0], 1'b0};
            fin_c_s = work_q[WIDTH-1];
          end else begin
            work_d  = {1'b0, work_q[WIDTH-1:1]};
            fin_c_s = work_q[0];
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d    = S_IDLE;
            fin_res_s  = work_d;
            fin_zn_s   = 1'b1;
            fin_cu_s   = 1'b1;
            fin_done_s = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      S_MUL: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          // Conditional add into a WIDTH+1-bit partial sum. The {carry, hi, lo} product then shifts right.
          if (acc_lo_q[0]) begin
            psum_s = {1'b0, acc_hi_q} + {1'b0, mcand_q};
          end else begin
            psum_s = {1'b0, acc_hi_q};
          end
          acc_hi_d = psum_s[WIDTH:1];
          acc_lo_d = {psum_s[0], acc_lo_q[WIDTH-1:1]};
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d    = S_IDLE;
            fin_res_s  = acc_lo_d;
            fin_c_s    = |acc_hi_d;
            fin_zn_s   = 1'b1;
            fin_cu_s   = 1'b1;
            fin_done_s = 1'b1;
          end else begin
            state_d = S_MUL;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fin_done_s) begin
      result_d    = fin_res_s;
      out_valid_d = 1'b1;
      if (fin_zn_s) begin
        ccr_d[1] = fin_res_s[WIDTH-1];
        ccr_d[0] = (fin_res_s == {WIDTH{1'b0}});
      end else begin
        ccr_d[1:0] = ccr_q[1:0];
      end
      if (fin_cu_s) begin
        ccr_d[2] = fin_c_s;
      end else begin
        ccr_d[2] = ccr_q[2];
      end
    end else begin
      result_d = result_q;
    end

    // An RTI restore overrides any flags produced by an op completing on the same edge.
    if (bus.ccr_load) begin
      ccr_d = bus.ccr_in;
    end else begin
      ccr_d = ccr_d;
    end
  end

  // State, datapath and output registers. An asynchronous reset discards any partial work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      work_q      <= {WIDTH{1'b0}};
      shl_q       <= 1'b0;
      mcand_q     <= {WIDTH{1'b0}};
      acc_hi_q    <= {WIDTH{1'b0}};
      acc_lo_q    <= {WIDTH{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      ccr_q       <= 3'b000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      shl_q       <= shl_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      result_q    <= result_d;
      ccr_q       <= ccr_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_exec_alu_mc.sv
// Scoreboard bench for exec_alu_mc (WIDTH=16): a driver issues ops and pushes the
// reference-model expectation, and an independent monitor pops and compares on out_valid.
module tb_exec_alu_mc;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_alu_mc_if #(.WIDTH(W)) bus();
  exec_alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] res;
    logic [2:0]  ccr;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [2:0]  m_ccr  = 3'b000;
  logic [15:0] m_res  = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: the op's effect from plain arithmetic, then push the expectation.
  task automatic model(input logic [3:0] o, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] p, input logic cl, input logic [2:0] ci, input int acc_cyc);
    int unsigned a, b, r, full;
    int n, lat;
    bit zn, cu, c;
    exp_t e;
    a = s; b = d; n = s % 16; zn = 0; cu = 0; c = 0; lat = 0; r = 0;
    case (o)
      4'd0: begin full = a + b; r = full; c = (full > 65535); zn = 1; cu = 1; end
      4'd1: begin r = b - a; c = (b < a); zn = 1; cu = 1; end
      4'd2: begin r = a & b; zn = 1; end
      4'd3: begin r = a | b; zn = 1; end
      4'd4: begin r = ~b; zn = 1; end
      4'd5: begin r = b + 1; c = (b == 65535); zn = 1; cu = 1; end
      4'd6: begin r = b - 1; c = (b == 0); zn = 1; cu = 1; end
      4'd7: begin r = b << n; zn = 1; if (n > 0) begin c = ((b >> (16 - n)) & 1) != 0; cu = 1; lat = n; end end
      4'd8: begin r = b >> n; zn = 1; if (n > 0) begin c = ((b >> (n - 1)) & 1) != 0; cu = 1; lat = n; end end
      4'd9: begin full = a * b; r = full; c = ((full >> 16) != 0); zn = 1; cu = 1; lat = 16; end
      4'd10: r = a;
      4'd11: r = p;
      default: r = 0;
    endcase
    r = r & 32'h0000FFFF;
    if (cl && lat > 0) m_ccr = ci;
    if (zn) begin m_ccr[1] = r[15]; m_ccr[0] = (r == 0); end
    if (cu) m_ccr[2] = c;
    if (cl && lat == 0) m_ccr = ci;
    m_res = r[15:0];
    e.res = r[15:0];
    e.ccr = m_ccr;
    e.cyc = acc_cyc + lat;
    sbq.push_back(e);
  endtask

  // Driver: wait (bounded) for in_ready, present the op for one accept edge, then model it.
  task automatic issue(input logic [3:0] o, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] p, input logic cl, input logic [2:0] ci, input bit expect_done);
    int w;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready still %b after %0d cycles", bus.in_ready, w);
    end
    bus.in_valid = 1'b1; bus.op = o; bus.src = s; bus.dst = d; bus.in_port = p;
    bus.ccr_load = cl; bus.ccr_in = ci;
    @(posedge clk); #1;
    if (expect_done) model(o, s, d, p, cl, ci, cyc);
    bus.in_valid = 1'b0; bus.ccr_load = 1'b0;
    bus.src = 16'($urandom); bus.dst = 16'($urandom);
  endtask

  // Monitor: every out_valid pulse must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid: got result %h ccr %b, expected no completion", bus.result, bus.ccr);
      end else begin
        mon_e = sbq.pop_front();
        checks++;
        if (bus.result !== mon_e.res || bus.ccr !== mon_e.ccr || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL scoreboard: got res %h ccr %b cyc %0d, expected res %h ccr %b cyc %0d",
                   bus.result, bus.ccr, cyc, mon_e.res, mon_e.ccr, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    logic [3:0]  ro;
    logic [15:0] rs, rd, rp;
    logic        rcl;
    logic [2:0]  rci;
    int          gap, k;

    bus.in_valid = 1'b0; bus.op = 4'd0; bus.src = 16'h0; bus.dst = 16'h0; bus.in_port = 16'h0;
    bus.flush = 1'b0; bus.ccr_load = 1'b0; bus.ccr_in = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_result", bus.result, 16'h0000);
    check("reset_ccr", bus.ccr, 3'b000);
    @(posedge clk); #1;

    // Directed: arithmetic with flag effects, issued back to back.
    issue(4'd0, 16'h0001, 16'hFFFF, 16'h0, 1'b0, 3'b000, 1'b1);
    check("add_result", bus.result, 16'h0000);
    check("add_ccr", bus.ccr, 3'b101);
    issue(4'd1, 16'h0002, 16'h0001, 16'h0, 1'b0, 3'b000, 1'b1);
    check("sub_result", bus.result, 16'hFFFF);
    check("sub_ccr", bus.ccr, 3'b110);
    issue(4'd2, 16'h8000, 16'hFFFF, 16'h0, 1'b0, 3'b000, 1'b1);
    check("and_ccr_c_kept", bus.ccr, 3'b110);
    issue(4'd10, 16'h0000, 16'h1234, 16'h0, 1'b0, 3'b000, 1'b1);
    check("pass_ccr_kept", bus.ccr, 3'b110);

    // Directed: shifts and multiplies.
    issue(4'd7, 16'h0003, 16'hC001, 16'h0, 1'b0, 3'b000, 1'b1);
    check("shl_in_ready_low", bus.in_ready, 0);
    check("shl_busy", bus.busy, 1);
    issue(4'd8, 16'h0002, 16'h0006, 16'h0, 1'b0, 3'b000, 1'b1);
    issue(4'd7, 16'h0010, 16'h8421, 16'h0, 1'b0, 3'b000, 1'b1);
    issue(4'd9, 16'h0100, 16'h0100, 16'h0, 1'b0, 3'b000, 1'b1);
    issue(4'd9, 16'h0003, 16'h0005, 16'h0, 1'b0, 3'b000, 1'b1);
    issue(4'd11, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 3'b000, 1'b1);

    // Flush at cycle 5 of a MUL: back to idle, no completion, outputs held.
    issue(4'd9, 16'h1234, 16'h5678, 16'h0, 1'b0, 3'b000, 1'b0);
    repeat (4) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_result_held", bus.result, m_res);
    check("flush_ccr_held", bus.ccr, m_ccr);
    // Flush together with a request in IDLE discards the op.
    bus.in_valid = 1'b1; bus.op = 4'd0; bus.src = 16'h1111; bus.dst = 16'h2222; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush_idle_result_held", bus.result, m_res);
    repeat (20) @(posedge clk);
    #1;

    // CCR restore on the completion edge of an ADD.
    issue(4'd0, 16'h0001, 16'h0002, 16'h0, 1'b1, 3'b010, 1'b1);
    check("ccr_load_ccr", bus.ccr, 3'b010);
    check("ccr_load_result", bus.result, 16'h0003);

    // Randomized ops with occasional gaps and CCR restores.
    for (int i = 0; i < 300; i++) begin
      ro  = 4'($urandom_range(0, 15));
      rs  = 16'($urandom);
      rd  = 16'($urandom);
      rp  = 16'($urandom);
      rcl = ($urandom_range(0, 9) == 0);
      rci = 3'($urandom);
      if ($urandom_range(0, 3) == 0) rd = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
      issue(ro, rs, rd, rp, rcl, rci, 1'b1);
      gap = $urandom_range(0, 6);
      if (gap > 3) begin
        repeat (gap - 3) @(posedge clk);
        #1;
      end
    end

    k = 0;
    while (sbq.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_queue_empty", sbq.size(), 0);

    // Reset in the middle of a MUL clears everything at once.
    issue(4'd9, 16'h0003, 16'h0005, 16'h0, 1'b0, 3'b000, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_in_ready", bus.in_ready, 1);
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_result", bus.result, 16'h0000);
    check("rst_mid_ccr", bus.ccr, 3'b000);
    m_ccr = 3'b000;
    m_res = 16'h0000;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    issue(4'd6, 16'h0000, 16'h0000, 16'h0, 1'b0, 3'b000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
